// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared types and constants for the video shifter
// Holds the resolution enum, the register map constant, the RGB width and a
// helper that maps the raw 2-bit resolution register onto a display mode.
package shifter_pkg;

  typedef enum logic [1:0] {
    RES_LOW  = 2'd0,
    RES_MED  = 2'd1,
    RES_HIGH = 2'd2
  } res_e;

  localparam logic [4:0] ADDR_RES = 5'd16;
  localparam int         RGB_W    = 12;

  // Resolution value 3 is not a distinct mode; hardware treats it as medium.
  function automatic res_e decode_res(input logic [1:0] res);
    case (res)
      2'd0:    decode_res = RES_LOW;
      2'd2:    decode_res = RES_HIGH;
      default: decode_res = RES_MED;
    endcase
  endfunction

endpackage

// File: rtl/shifter_regs.sv
// rtl/shifter_regs.sv - CPU-visible palette and resolution register file
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   cs_ni, rw_i        chip select (active low), 1 = read / 0 = write
//   addr_i             0-15 palette entries, 16 resolution
//   data_i             write data (only the low 12 bits are ever stored)
//   palette_o, res_o   current register contents for the pixel path
//   data_out_o, oe_o   registered read data and its valid flag
module shifter_regs
  import shifter_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cs_ni,
  input  logic                   rw_i,
  input  logic [4:0]             addr_i,
  input  logic [11:0]            data_i,
  output logic [15:0][RGB_W-1:0] palette_o,
  output logic [1:0]             res_o,
  output logic [15:0]            data_out_o,
  output logic                   oe_o
);

  logic [15:0][RGB_W-1:0] palette_q, palette_d;
  logic [1:0]             res_q, res_d;
  logic [15:0]            dout_q, dout_d;
  logic                   oe_q, oe_d;
  logic                   wr_en, rd_en;

  assign wr_en = ~cs_ni & ~rw_i;
  assign rd_en = ~cs_ni &  rw_i;

  always_comb begin
    palette_d = palette_q;
    res_d     = res_q;
    oe_d      = rd_en;
    dout_d    = '0;
    if (wr_en) begin
      if (!addr_i[4]) palette_d[addr_i[3:0]] = data_i;
      else if (addr_i == ADDR_RES) res_d = data_i[1:0];
    end
    // Unmapped addresses read back as zero but still raise oe.
    if (rd_en) begin
      if (!addr_i[4]) dout_d = {4'h0, palette_q[addr_i[3:0]]};
      else if (addr_i == ADDR_RES) dout_d = {14'h0, res_q};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      palette_q <= '0;
      res_q     <= '0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
    end else begin
      palette_q <= palette_d;
      res_q     <= res_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
    end
  end

  assign palette_o  = palette_q;
  assign res_o      = res_q;
  assign data_out_o = dout_q;
  assign oe_o       = oe_q;

endmodule

// File: rtl/shifter.sv
// rtl/shifter.sv - bitplane video shifter with palette lookup
// Ports:
//   CLOCK_32, RESET_N  pixel clock, asynchronous active-low reset
//   de                 display enable (0 = border, shows palette entry 0)
//   cs, rw, addr       register access (cs active low, rw 1 = read)
//   load, data         active-low video word strobe and shared data bus
//   data_out, oe       register read data and valid
//   r, g, b            registered 4-bit colour outputs
module shifter
  import shifter_pkg::*;
(
  input  logic        CLOCK_32,
  input  logic        RESET_N,
  input  logic        de,
  input  logic        cs,
  input  logic        load,
  input  logic [15:0] data,
  output logic [15:0] data_out,
  input  logic        rw,
  input  logic [4:0]  addr,
  output logic        oe,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);

  logic [15:0][RGB_W-1:0] palette;
  logic [1:0]             res_raw;
  res_e                   mode;

  shifter_regs u_regs (
    .clk_i      (CLOCK_32),
    .rst_ni     (RESET_N),
    .cs_ni      (cs),
    .rw_i       (rw),
    .addr_i     (addr),
    .data_i     (data[11:0]),
    .palette_o  (palette),
    .res_o      (res_raw),
    .data_out_o (data_out),
    .oe_o       (oe)
  );

  assign mode = decode_res(res_raw);

  logic [2:0] words_n;    // words per group
  logic [1:0] div_max;    // clocks per pixel minus one
  logic [3:0] plane_mask; // planes that contribute to the colour index

  always_comb begin
    case (mode)
      RES_HIGH: begin words_n = 3'd1; div_max = 2'd0; plane_mask = 4'h1; end
      RES_MED:  begin words_n = 3'd2; div_max = 2'd1; plane_mask = 4'h3; end
      default:  begin words_n = 3'd4; div_max = 2'd3; plane_mask = 4'hF; end
    endcase
  end

  logic                  load_prev_q;
  logic [1:0]            count_q, count_d;
  logic [3:0][15:0]      buf_q, buf_d;
  logic [3:0][15:0]      shift_q, shift_d;
  logic [1:0]            div_q, div_d;
  logic [RGB_W-1:0]      rgb_q, rgb_d;
  logic                  load_rise;
  logic [3:0]            index;

  // load_prev resets low, so a strobe already idle-high at reset release
  // is taken as the first word of a group.
  assign load_rise = load & ~load_prev_q;

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    shift_d = shift_q;
    div_d   = div_q;

    if (div_q >= div_max) begin
      div_d = 2'd0;
      for (int p = 0; p < 4; p++) shift_d[p] = {shift_q[p][14:0], 1'b0};
    end else begin
      div_d = div_q + 2'd1;
    end

    if (load_rise) begin
      buf_d[count_q] = data;
      // ">=" rather than "==" so a mode change mid-group cannot strand the
      // counter above the new group size.
      if ({1'b0, count_q} + 3'd1 >= words_n) begin
        count_d = 2'd0;
        shift_d = buf_d;
        div_d   = 2'd0;
      end else begin
        count_d = count_q + 2'd1;
      end
    end
  end

  assign index = {shift_q[3][15], shift_q[2][15], shift_q[1][15], shift_q[0][15]}
                 & plane_mask;

  // High resolution drives black for a set pixel when palette[0] bit 0 is clear.
  always_comb begin
    rgb_d = palette[0];
    if (de) begin
      if (mode == RES_HIGH) rgb_d = {RGB_W{~(shift_q[0][15] ^ palette[0][0])}};
      else                  rgb_d = palette[index];
    end
  end

  always_ff @(posedge CLOCK_32 or negedge RESET_N) begin
    if (!RESET_N) begin
      load_prev_q <= 1'b0;
      count_q     <= '0;
      buf_q       <= '0;
      shift_q     <= '0;
      div_q       <= '0;
      rgb_q       <= '0;
    end else begin
      load_prev_q <= load;
      count_q     <= count_d;
      buf_q       <= buf_d;
      shift_q     <= shift_d;
      div_q       <= div_d;
      rgb_q       <= rgb_d;
    end
  end

  assign r = rgb_q[11:8];
  assign g = rgb_q[7:4];
  assign b = rgb_q[3:0];

endmodule

// File: tb/tb_shifter.sv
// tb/tb_shifter.sv - self-checking bench for the video shifter
module tb_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de = 1'b1;
  logic        cs = 1'b1;
  logic        load = 1'b0;
  logic        rw = 1'b1;
  logic [15:0] data = '0;
  logic [4:0]  addr = '0;
  logic [15:0] data_out;
  logic        oe;
  logic [3:0]  r, g, b;

  always #5 clk = ~clk;

  shifter dut (
    .CLOCK_32 (clk),
    .RESET_N  (rst_n),
    .de       (de),
    .cs       (cs),
    .load     (load),
    .data     (data),
    .data_out (data_out),
    .rw       (rw),
    .addr     (addr),
    .oe       (oe),
    .r        (r),
    .g        (g),
    .b        (b)
  );

  int errors = 0;
  int checks = 0;

  logic [11:0] mpal [16];
  logic [1:0]  mres;
  logic [15:0] mwords [4];

  typedef struct {
    logic [4:0]  a;
    logic [15:0] w;
    logic [15:0] e;
  } reg_vec_t;
  reg_vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mpal[i] = 12'h000;
    mres = 2'd0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    cs = 1'b0; rw = 1'b0; addr = a; data = d;
    tick();
    cs = 1'b1; rw = 1'b1;
    if (a < 5'd16) mpal[a[3:0]] = d[11:0];
    else if (a == 5'd16) mres = d[1:0];
  endtask

  task automatic rd(input logic [4:0] a, input logic [15:0] exp, input string name);
    cs = 1'b0; rw = 1'b1; addr = a;
    tick();
    chk({name, " oe"}, {15'h0, oe}, 16'h0001);
    chk(name, data_out, exp);
    cs = 1'b1;
    tick();
    chk({name, " oe idle"}, {15'h0, oe}, 16'h0000);
    chk({name, " dout idle"}, data_out, 16'h0000);
  endtask

  // Words per group and clocks per pixel happen to be the same number.
  function automatic int group_n(input logic [1:0] res);
    if (res == 2'd2) return 1;
    if (res == 2'd0) return 4;
    return 2;
  endfunction

  function automatic logic [11:0] exp_pixel(input int i);
    int n, bitpos, idx;
    n = group_n(mres);
    bitpos = 15 - i;
    if (mres == 2'd2) return (mwords[0][bitpos] == mpal[0][0]) ? 12'hFFF : 12'h000;
    idx = 0;
    for (int p = 0; p < n; p++) if (mwords[p][bitpos]) idx += (1 << p);
    return mpal[idx];
  endfunction

  task automatic load_word(input logic [15:0] w);
    load = 1'b0; data = w;
    tick();
    load = 1'b1;
    tick();
  endtask

  task automatic load_group();
    for (int p = 0; p < group_n(mres); p++) load_word(mwords[p]);
  endtask

  task automatic check_stream(input string name);
    int n;
    n = group_n(mres);
    for (int j = 0; j < 16 * n; j++) begin
      tick();
      chk($sformatf("%s px%0d clk%0d", name, j / n, j % n), {4'h0, r, g, b},
          {4'h0, exp_pixel(j / n)});
    end
  endtask

  initial begin
    tbl[0] = '{5'd15, 16'h0FFF, 16'h0FFF};
    tbl[1] = '{5'd16, 16'h0003, 16'h0003};
    tbl[2] = '{5'd16, 16'hFFFE, 16'h0002};
    tbl[3] = '{5'd3,  16'hABCD, 16'h0BCD};
    tbl[4] = '{5'd17, 16'h1234, 16'h0000};
    tbl[5] = '{5'd31, 16'hFFFF, 16'h0000};
    tbl[6] = '{5'd0,  16'h0000, 16'h0000};
    model_reset();

    // Reset state, with load low so no word is counted on release.
    rst_n = 1'b0;
    tick(); tick();
    chk("reset rgb", {4'h0, r, g, b}, 16'h0000);
    chk("reset oe", {15'h0, oe}, 16'h0000);
    chk("reset dout", data_out, 16'h0000);
    rst_n = 1'b1;
    tick();
    rd(5'd5, 16'h0000, "reset palette5");

    // Register write/read table.
    for (int i = 0; i < 7; i++) begin
      wr(tbl[i].a, tbl[i].w);
      rd(tbl[i].a, tbl[i].e, $sformatf("reg vec%0d", i));
    end

    // Load held high through reset counts as word 0; three pulses finish LOW group.
    rst_n = 1'b0; load = 1'b1; data = 16'hFFFF;
    tick();
    model_reset();
    rst_n = 1'b1;
    tick();
    wr(5'd1, 16'h0123);
    load_word(16'h0000);
    load_word(16'h0000);
    tick();
    chk("low no early xfer", {4'h0, r, g, b}, 16'h0000);
    load_word(16'h0000);
    mwords = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    check_stream("low 0x123");

    // Medium: only pixels 11 and 15 reach index 3.
    wr(5'd16, 16'h0001);
    wr(5'd1, 16'h0000);
    wr(5'd2, 16'h0000);
    wr(5'd3, 16'h0FFF);
    mwords = '{16'h1B1B, 16'h0055, 16'h0000, 16'h0000};
    load_group();
    check_stream("med");

    // High: alternating pixels, first one black.
    wr(5'd16, 16'h0002);
    mwords = '{16'hAAAA, 16'h0000, 16'h0000, 16'h0000};
    load_group();
    check_stream("high");

    // Random modes, palettes and words against the model.
    for (int it = 0; it < 6; it++) begin
      wr(5'd16, 16'($urandom_range(0, 3)));
      for (int a = 0; a < 16; a++) wr(5'(a), 16'($urandom));
      for (int p = 0; p < 4; p++) mwords[p] = 16'($urandom);
      load_group();
      check_stream($sformatf("rand%0d", it));
    end

    // Border mid-group shows palette 0 while shifting continues.
    wr(5'd16, 16'h0000);
    wr(5'd0, 16'h00A5);
    for (int p = 0; p < 4; p++) mwords[p] = 16'($urandom);
    load_group();
    tick(); tick(); tick();
    de = 1'b0;
    tick();
    chk("border 1", {4'h0, r, g, b}, 16'h00A5);
    tick();
    chk("border 2", {4'h0, r, g, b}, 16'h00A5);
    de = 1'b1;
    tick(); tick();

    // Reset mid-shift clears outputs at once and restarts word counting.
    rst_n = 1'b0; load = 1'b1; data = 16'h8000;
    #1;
    chk("async reset rgb", {4'h0, r, g, b}, 16'h0000);
    chk("async reset oe", {15'h0, oe}, 16'h0000);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    wr(5'd1, 16'h0456);
    load_word(16'h0000);
    load_word(16'h0000);
    load_word(16'h0000);
    mwords = '{16'h8000, 16'h0000, 16'h0000, 16'h0000};
    check_stream("post reset");
    rd(5'd16, 16'h0000, "post reset res");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
